// File: rtl/man_link_pkg.sv
// Shared definitions for the Manchester link supervisor.
//   STATE_W/TIMER_W/CNT_W : field widths
//   S_*                   : link_state encodings exposed to the host
//   DEF_*                 : default timing constants in 20 MHz cycles
package man_link_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned TIMER_W = 20;
    localparam int unsigned CNT_W   = 8;

    localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] S_RESET_DET = 3'd1;
    localparam logic [STATE_W-1:0] S_ACQUIRE   = 3'd2;
    localparam logic [STATE_W-1:0] S_QUALIFY   = 3'd3;
    localparam logic [STATE_W-1:0] S_LINKED    = 3'd4;
    localparam logic [STATE_W-1:0] S_HOLDOFF   = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = S_IDLE,
        ST_RESET_DET = S_RESET_DET,
        ST_ACQUIRE   = S_ACQUIRE,
        ST_QUALIFY   = S_QUALIFY,
        ST_LINKED    = S_LINKED,
        ST_HOLDOFF   = S_HOLDOFF
    } state_t;

    localparam logic [TIMER_W-1:0] DEF_RST_CYC     = 20'd4;
    localparam logic [TIMER_W-1:0] DEF_ACQ_TIMEOUT = 20'd200000;
    localparam logic [TIMER_W-1:0] DEF_QUAL_CYC    = 20'd2000;
    localparam logic [TIMER_W-1:0] DEF_DROP_CYC    = 20'd40;
    localparam logic [TIMER_W-1:0] DEF_HOLD_CYC    = 20'd20000;

endpackage

// File: rtl/man_link_ctrl_if.sv
// Host/detector-facing signal bundle of the link supervisor.
//   master : host + detector side (drives enables and detector verdicts)
//   slave  : supervisor side (drives detector reset, decoder enable, status)
interface man_link_ctrl_if;
    import man_link_pkg::*;

    logic               link_en;
    logic               cnt_clr;
    logic               lock_stat;
    logic               pulse_err;
    logic               det_clr_n;
    logic               dec_en;
    logic               link_up;
    logic [STATE_W-1:0] link_state;
    logic [CNT_W-1:0]   err_cnt;
    logic [CNT_W-1:0]   relock_cnt;

    modport master (
        output link_en, cnt_clr, lock_stat, pulse_err,
        input  det_clr_n, dec_en, link_up, link_state, err_cnt, relock_cnt
    );

    modport slave (
        input  link_en, cnt_clr, lock_stat, pulse_err,
        output det_clr_n, dec_en, link_up, link_state, err_cnt, relock_cnt
    );

endinterface

// File: rtl/sat_cnt8.sv
// 8-bit saturating event counter; synchronous clear beats increment.
//   clk_20M : clock            clr     : async active-low reset
//   inc     : count one event  cnt_clr : synchronous clear
//   cnt     : registered count, holds at 255
module sat_cnt8
    import man_link_pkg::*;
(
    input  logic             clk_20M,
    input  logic             clr,
    input  logic             inc,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk_20M or negedge clr) begin
        if (!clr) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/man_link_ctrl.sv
// Link supervisor for one Manchester receive channel: re-arms the lock
// detector, qualifies its verdicts over time, gates the decoder and keeps
// failure/relock statistics.
//   clk_20M : 20 MHz clock     clr : async active-low reset
//   bus     : slave side of man_link_ctrl_if (host controls, detector
//             verdicts, detector reset, decoder enable, status, counters)
module man_link_ctrl
    import man_link_pkg::*;
#(
    parameter logic [TIMER_W-1:0] RST_CYC     = DEF_RST_CYC,
    parameter logic [TIMER_W-1:0] ACQ_TIMEOUT = DEF_ACQ_TIMEOUT,
    parameter logic [TIMER_W-1:0] QUAL_CYC    = DEF_QUAL_CYC,
    parameter logic [TIMER_W-1:0] DROP_CYC    = DEF_DROP_CYC,
    parameter logic [TIMER_W-1:0] HOLD_CYC    = DEF_HOLD_CYC
) (
    input  logic            clk_20M,
    input  logic            clr,
    man_link_ctrl_if.slave  bus
);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TIMER_W-1:0] drop_q, drop_d;
    logic               det_clr_n_q, det_clr_n_d;
    logic               dec_en_q, dec_en_d;
    logic               link_up_q, link_up_d;
    logic               err_inc, relock_inc, good;

    // State, timers and registered outputs
    always_ff @(posedge clk_20M or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            drop_q      <= '0;
            det_clr_n_q <= 1'b0;
            dec_en_q    <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            drop_q      <= drop_d;
            det_clr_n_q <= det_clr_n_d;
            dec_en_q    <= dec_en_d;
            link_up_q   <= link_up_d;
        end
    end

    // Next state, counter events and next output values
    always_comb begin
        state_d     = state_q;
        drop_d      = '0;
        err_inc     = 1'b0;
        relock_inc  = 1'b0;
        good        = bus.lock_stat && !bus.pulse_err;

        if (!bus.link_en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_RESET_DET;
                ST_RESET_DET: begin
                    if (timer_q == RST_CYC - TIMER_W'(1)) state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    // Lock is checked first so it wins in the timeout cycle
                    if (good) begin
                        state_d = ST_QUALIFY;
                    end else if (bus.pulse_err || (timer_q == ACQ_TIMEOUT - TIMER_W'(1))) begin
                        state_d = ST_HOLDOFF;
                        err_inc = 1'b1;
                    end
                end
                ST_QUALIFY: begin
                    if (!good) begin
                        state_d = ST_HOLDOFF;
                        err_inc = 1'b1;
                    end else if (timer_q == QUAL_CYC - TIMER_W'(1)) begin
                        state_d = ST_LINKED;
                    end
                end
                ST_LINKED: begin
                    // Idle line (no lock, no error) is treated as a bad cycle too
                    if (!good) begin
                        if (drop_q == DROP_CYC - TIMER_W'(1)) begin
                            state_d    = ST_HOLDOFF;
                            relock_inc = 1'b1;
                        end else begin
                            drop_d = drop_q + TIMER_W'(1);
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (timer_q == HOLD_CYC - TIMER_W'(1)) state_d = ST_RESET_DET;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        timer_d     = (state_d == state_q) ? timer_q + TIMER_W'(1) : '0;
        det_clr_n_d = !((state_d == ST_IDLE) || (state_d == ST_RESET_DET));
        dec_en_d    = (state_d == ST_LINKED);
        link_up_d   = (state_d == ST_LINKED);
    end

    sat_cnt8 u_err_cnt (
        .clk_20M (clk_20M),
        .clr     (clr),
        .inc     (err_inc),
        .cnt_clr (bus.cnt_clr),
        .cnt     (bus.err_cnt)
    );

    sat_cnt8 u_relock_cnt (
        .clk_20M (clk_20M),
        .clr     (clr),
        .inc     (relock_inc),
        .cnt_clr (bus.cnt_clr),
        .cnt     (bus.relock_cnt)
    );

    assign bus.det_clr_n  = det_clr_n_q;
    assign bus.dec_en     = dec_en_q;
    assign bus.link_up    = link_up_q;
    assign bus.link_state = state_q;

endmodule

// File: tb/tb_man_link_ctrl.sv
// Self-checking bench for man_link_ctrl: a scaled-timing instance checked
// every cycle against a phase/elapsed-time reference model, plus an
// all-ones-timing instance driven from a vector table and saturation runs.
module tb_man_link_ctrl;

    localparam int unsigned P_RST  = 4;
    localparam int unsigned P_ACQ  = 300;
    localparam int unsigned P_QUAL = 100;
    localparam int unsigned P_DROP = 40;
    localparam int unsigned P_HOLD = 200;

    logic clk_20M = 1'b0;
    logic clr;
    always #25 clk_20M = ~clk_20M;

    man_link_ctrl_if bus ();
    man_link_ctrl_if sbus ();

    man_link_ctrl #(
        .RST_CYC(20'(P_RST)), .ACQ_TIMEOUT(20'(P_ACQ)), .QUAL_CYC(20'(P_QUAL)),
        .DROP_CYC(20'(P_DROP)), .HOLD_CYC(20'(P_HOLD))
    ) u_dut (.clk_20M(clk_20M), .clr(clr), .bus(bus));

    man_link_ctrl #(
        .RST_CYC(20'd1), .ACQ_TIMEOUT(20'd1), .QUAL_CYC(20'd1),
        .DROP_CYC(20'd1), .HOLD_CYC(20'd1)
    ) u_sat (.clk_20M(clk_20M), .clr(clr), .bus(sbus));

    int total = 0;
    int bad   = 0;

    // Reference model: link phase plus cycles spent in it
    typedef enum {M_IDLE, M_RST, M_ACQ, M_QUAL, M_LINK, M_HOLD} mph_t;
    mph_t        ph;
    int unsigned age, bad_run, m_err, m_rel;

    function automatic logic [2:0] code(input mph_t p);
        case (p)
            M_IDLE:  return 3'd0;
            M_RST:   return 3'd1;
            M_ACQ:   return 3'd2;
            M_QUAL:  return 3'd3;
            M_LINK:  return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    task automatic model_reset();
        ph = M_IDLE; age = 0; bad_run = 0; m_err = 0; m_rel = 0;
    endtask

    task automatic model_edge(input logic le, input logic cc, input logic lk, input logic pe);
        mph_t nx;
        bit   good, fail, drop;
        good = lk && !pe; fail = 0; drop = 0; nx = ph;
        if (!le) nx = M_IDLE;
        else case (ph)
            M_IDLE: nx = M_RST;
            M_RST:  if (age + 1 == P_RST) nx = M_ACQ;
            M_ACQ:  if (good) nx = M_QUAL;
                    else if (pe || age + 1 == P_ACQ) begin nx = M_HOLD; fail = 1; end
            M_QUAL: if (!good) begin nx = M_HOLD; fail = 1; end
                    else if (age + 1 == P_QUAL) nx = M_LINK;
            M_LINK: if (!good && bad_run + 1 == P_DROP) begin nx = M_HOLD; drop = 1; end
            M_HOLD: if (age + 1 == P_HOLD) nx = M_RST;
            default: nx = M_IDLE;
        endcase
        bad_run = (ph == M_LINK && nx == M_LINK && !good) ? bad_run + 1 : 0;
        age     = (nx == ph) ? age + 1 : 0;
        if (cc) begin
            m_err = 0; m_rel = 0;
        end else begin
            if (fail && m_err < 255) m_err++;
            if (drop && m_rel < 255) m_rel++;
        end
        ph = nx;
    endtask

    function automatic logic [31:0] model_vec();
        logic up;
        up = (ph == M_LINK);
        return 32'({code(ph), !(ph == M_IDLE || ph == M_RST), up, up, 8'(m_err), 8'(m_rel)});
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({bus.link_state, bus.det_clr_n, bus.dec_en, bus.link_up, bus.err_cnt, bus.relock_cnt});
    endfunction

    function automatic logic [31:0] sat_vec();
        return 32'({sbus.link_state, sbus.det_clr_n, sbus.dec_en, sbus.link_up, sbus.err_cnt, sbus.relock_cnt});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the applied inputs, compare after the edge
    task automatic tick();
        model_edge(bus.link_en, bus.cnt_clr, bus.lock_stat, bus.pulse_err);
        @(posedge clk_20M);
        #1;
        chk("cycle", dut_vec(), model_vec());
    endtask

    task automatic wait_state(input logic [2:0] st, input int unsigned limit, input string name);
        int unsigned n = 0;
        while (bus.link_state != st && n < limit) begin tick(); n++; end
        chk(name, 32'(bus.link_state), 32'(st));
    endtask

    typedef struct {
        logic       le, cc, lk, pe;
        logic [2:0] st;
        logic       det, up;
        logic [7:0] err, rel;
    } vec_t;
    vec_t tbl [15];

    initial begin
        int unsigned n, low, rise;

        // All-ones timing: every timed state lasts one cycle
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'd0, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 8'd1, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 8'd1, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 8'd1, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 8'd1, 8'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 8'd1, 8'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 8'd1, 8'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 8'd1, 8'd1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 8'd1, 8'd1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 8'd1, 8'd1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 8'd2, 8'd1};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 8'd0};

        clr = 1'b0;
        bus.link_en = 1'b0; bus.cnt_clr = 1'b0; bus.lock_stat = 1'b0; bus.pulse_err = 1'b0;
        sbus.link_en = 1'b0; sbus.cnt_clr = 1'b0; sbus.lock_stat = 1'b0; sbus.pulse_err = 1'b0;
        model_reset();
        #120;
        chk("reset_main", dut_vec(), 32'd0);
        chk("reset_sat", sat_vec(), 32'd0);
        @(negedge clk_20M);
        clr = 1'b1;

        // Main instance idles with link_en=0 while the table runs on the other one
        foreach (tbl[i]) begin
            sbus.link_en = tbl[i].le; sbus.cnt_clr = tbl[i].cc;
            sbus.lock_stat = tbl[i].lk; sbus.pulse_err = tbl[i].pe;
            tick();
            chk($sformatf("tbl%0d", i), sat_vec(),
                32'({tbl[i].st, tbl[i].det, tbl[i].up, tbl[i].up, tbl[i].err, tbl[i].rel}));
        end

        // Endless acquisition failures saturate err_cnt
        sbus.link_en = 1'b1; sbus.lock_stat = 1'b0;
        repeat (1000) tick();
        chk("sat_255", 32'(sbus.err_cnt), 32'd255);
        n = 0;
        while (sbus.link_state != 3'd2 && n < 5) begin tick(); n++; end
        sbus.cnt_clr = 1'b1;
        tick();
        chk("clr_beats_inc", 32'({sbus.link_state, sbus.err_cnt}), 32'({3'd5, 8'd0}));
        sbus.cnt_clr = 1'b0;
        repeat (3) tick();
        chk("inc_after_clr", 32'(sbus.err_cnt), 32'd1);
        sbus.link_en = 1'b0;
        chk("idle_hold", dut_vec(), 32'd0);

        // Clean lock from the start
        bus.link_en = 1'b1; bus.lock_stat = 1'b1;
        low = 0; rise = 0;
        for (int e = 1; e <= int'(2 + P_RST + P_QUAL + 5); e++) begin
            tick();
            if (!bus.det_clr_n) low++;
            if (bus.link_up && rise == 0) rise = e;
        end
        chk("det_low_cycles", 32'(low), 32'(P_RST));
        chk("link_up_edge", 32'(rise), 32'(2 + P_RST + P_QUAL));
        chk("err_clean", 32'(bus.err_cnt), 32'd0);

        // Drop threshold: one short of the limit, then exactly the limit
        bus.lock_stat = 1'b0;
        repeat (P_DROP - 1) tick();
        chk("drop_short", 32'({bus.link_state, bus.relock_cnt}), 32'({3'd4, 8'd0}));
        bus.lock_stat = 1'b1;
        tick();
        bus.lock_stat = 1'b0;
        repeat (P_DROP) tick();
        chk("drop_full", 32'({bus.link_state, bus.dec_en, bus.relock_cnt}), 32'({3'd5, 1'b0, 8'd1}));

        // Acquisition timeout and hold-off length
        wait_state(3'd2, P_HOLD + P_RST + 10, "reach_acq");
        n = 0;
        while (bus.link_state != 3'd5 && n < P_ACQ + 10) begin tick(); n++; end
        chk("acq_len", 32'(n), 32'(P_ACQ));
        chk("err_timeout1", 32'(bus.err_cnt), 32'd1);
        n = 0;
        while (bus.det_clr_n && n < P_HOLD + 10) begin tick(); n++; end
        chk("hold_len", 32'(n), 32'(P_HOLD));
        wait_state(3'd5, P_RST + P_ACQ + 10, "timeout2");
        chk("err_timeout2", 32'(bus.err_cnt), 32'd2);

        // pulse_err mid-qualify, then link_en drop mid-qualify
        bus.lock_stat = 1'b1;
        wait_state(3'd3, P_HOLD + P_RST + 10, "reach_qual");
        repeat (P_QUAL / 2) tick();
        bus.pulse_err = 1'b1;
        tick();
        bus.pulse_err = 1'b0;
        chk("qual_perr", 32'({bus.link_state, bus.err_cnt}), 32'({3'd5, 8'd3}));
        wait_state(3'd3, P_HOLD + P_RST + 10, "reach_qual2");
        repeat (10) tick();
        bus.link_en = 1'b0;
        tick();
        chk("qual_disable", dut_vec(), 32'({3'd0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd1}));

        // Asynchronous reset while linked
        bus.link_en = 1'b1;
        wait_state(3'd4, P_RST + P_QUAL + 10, "relink");
        #5;
        clr = 1'b0;
        #1;
        chk("async_reset", dut_vec(), 32'd0);
        model_reset();
        @(negedge clk_20M);
        clr = 1'b1;

        // Randomized segments of line behaviour
        for (int s = 0; s < 200; s++) begin
            int unsigned mode, len;
            mode = $urandom_range(0, 4);
            len  = $urandom_range(1, 250);
            for (int i = 0; i < int'(len); i++) begin
                case (mode)
                    0: begin bus.lock_stat = 1'b1; bus.pulse_err = 1'b0; end
                    1: begin bus.lock_stat = 1'b0; bus.pulse_err = 1'b0; end
                    2: begin bus.lock_stat = 1'b1; bus.pulse_err = ($urandom_range(0, 99) == 0); end
                    3: begin bus.lock_stat = ($urandom_range(0, 9) != 0); bus.pulse_err = 1'b0; end
                    default: begin bus.lock_stat = 1'($urandom); bus.pulse_err = 1'($urandom); end
                endcase
                bus.link_en = ($urandom_range(0, 999) != 0);
                bus.cnt_clr = ($urandom_range(0, 499) == 0);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
